// File: rtl/sram_fifo_arb_if.sv
// sram_fifo_arb_if: client-side bundle of the multi-channel SRAM FIFO.
//   master : FIFO users (write/read requests, write data, flush).
//   slave  : the controller (acks, read data, per-channel status).
// Channel c of a packed per-channel vector sits at [c*W +: W].
interface sram_fifo_arb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18,
    parameter int NCH    = 2
);
    localparam int CH_W  = $clog2(NCH);
    localparam int REG_W = ADDR_W - CH_W;

    logic [NCH-1:0]             wr_req;
    logic [NCH*DATA_W-1:0]      wr_data;
    logic [NCH-1:0]             wr_ack;
    logic [NCH-1:0]             rd_req;
    logic [NCH-1:0]             rd_ack;
    logic [DATA_W-1:0]          rd_data;
    logic [NCH-1:0]             flush;
    logic [NCH-1:0]             empty;
    logic [NCH-1:0]             full;
    logic [NCH*(REG_W+1)-1:0]   count;

    modport master (
        output wr_req, wr_data, rd_req, flush,
        input  wr_ack, rd_ack, rd_data, empty, full, count
    );

    modport slave (
        input  wr_req, wr_data, rd_req, flush,
        output wr_ack, rd_ack, rd_data, empty, full, count
    );
endinterface

// File: rtl/sram_fifo_arb.sv
// sram_fifo_arb: shared asynchronous SRAM split into NCH ring-buffer FIFOs,
// one writer and one reader per channel, round-robin arbitrated, with a
// per-channel flush.
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : requests/acks, write/read data, flush, status
//   mem_addr, mem_dq  : SRAM word address and bidirectional data
//   ce_n, oe_n, we_n  : SRAM strobes (active low)
//   lb_n, ub_n        : byte lanes, always enabled
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | CE off; apply flushes, else arbitrate and latch the grant
// SETUP   | CE on, address stable, write data on the bus
// STROBE  | WE (write) or OE (read) asserted
// CAPTURE | strobes released, pointer and count updated
// ACK     | ack pulse to the granted requester, data bus released
module sram_fifo_arb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18,
    parameter int NCH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_fifo_arb_if.slave     bus,
    output logic [ADDR_W-1:0]  mem_addr,
    inout  wire  [DATA_W-1:0]  mem_dq,
    output logic               ce_n,
    output logic               oe_n,
    output logic               we_n,
    output logic               lb_n,
    output logic               ub_n
);
    localparam int CH_W  = $clog2(NCH);
    localparam int REG_W = ADDR_W - CH_W;
    localparam int CNT_W = REG_W + 1;
    localparam int NREQ  = 2 * NCH;
    localparam int RW    = $clog2(NREQ);
    localparam int CI_W  = (NCH > 1) ? CH_W : 1;
    localparam logic [CNT_W-1:0] CAP = {1'b1, {REG_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, ACK} state_t;

    state_t              state;
    state_t              state_nx;

    logic [REG_W-1:0]    wr_ptr [NCH];
    logic [REG_W-1:0]    rd_ptr [NCH];
    logic [CNT_W-1:0]    cnt    [NCH];

    logic [RW-1:0]       rr;
    logic [NREQ-1:0]     elig;
    logic                sel_vld;
    logic [RW-1:0]       sel_r;
    logic [CI_W-1:0]     sel_ch;
    logic [REG_W-1:0]    sel_ptr;

    logic                gnt_wr;
    logic [CI_W-1:0]     gnt_ch;
    logic [DATA_W-1:0]   wdata;
    logic                dq_oe;
    logic [NCH-1:0]      pend_flush;
    logic [NCH-1:0]      flush_all;

    assign lb_n      = 1'b0;
    assign ub_n      = 1'b0;
    assign mem_dq    = dq_oe ? wdata : {DATA_W{1'bz}};
    assign flush_all = pend_flush | bus.flush;

    // Eligibility is taken from the live counters rather than the registered
    // status, so a flush applied in the previous IDLE cycle is already seen.
    always_comb begin
        elig = '0;
        for (int c = 0; c < NCH; c++) begin
            elig[2*c]   = bus.wr_req[c] && (cnt[c] != CAP);
            elig[2*c+1] = bus.rd_req[c] && (cnt[c] != '0);
        end
    end

    // Search from rr upward with wrap; walking offsets downward lets the
    // smallest offset win. NREQ is a power of two, so the index wraps itself.
    always_comb begin
        sel_vld = 1'b0;
        sel_r   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig[rr + RW'(i)]) begin
                sel_vld = 1'b1;
                sel_r   = rr + RW'(i);
            end
        end
        sel_ch  = CI_W'(sel_r >> 1);
        sel_ptr = sel_r[0] ? rd_ptr[sel_ch] : wr_ptr[sel_ch];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        ce_n       = 1'b1;
        we_n       = 1'b1;
        oe_n       = 1'b1;
        dq_oe      = 1'b0;
        bus.wr_ack = '0;
        bus.rd_ack = '0;
        case (state)
            IDLE: begin
                if (flush_all == '0 && sel_vld) state_nx = SETUP;
            end
            SETUP: begin
                ce_n     = 1'b0;
                dq_oe    = gnt_wr;
                state_nx = STROBE;
            end
            STROBE: begin
                ce_n     = 1'b0;
                dq_oe    = gnt_wr;
                we_n     = ~gnt_wr;
                oe_n     = gnt_wr;
                state_nx = CAPTURE;
            end
            CAPTURE: begin
                ce_n     = 1'b0;
                dq_oe    = gnt_wr;
                state_nx = ACK;
            end
            ACK: begin
                ce_n = 1'b0;
                if (gnt_wr) bus.wr_ack[gnt_ch] = 1'b1;
                else        bus.rd_ack[gnt_ch] = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr          <= '0;
            gnt_wr      <= 1'b0;
            gnt_ch      <= '0;
            wdata       <= '0;
            mem_addr    <= '0;
            bus.rd_data <= '0;
            pend_flush  <= '0;
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
        end else begin
            if (state != IDLE) pend_flush <= pend_flush | bus.flush;
            case (state)
                IDLE: begin
                    pend_flush <= '0;
                    if (flush_all != '0) begin
                        for (int c = 0; c < NCH; c++) begin
                            if (flush_all[c]) begin
                                wr_ptr[c] <= '0;
                                rd_ptr[c] <= '0;
                                cnt[c]    <= '0;
                            end
                        end
                    end else if (sel_vld) begin
                        gnt_wr   <= ~sel_r[0];
                        gnt_ch   <= sel_ch;
                        rr       <= sel_r + RW'(1);
                        mem_addr <= (ADDR_W'(sel_ch) << REG_W) | ADDR_W'(sel_ptr);
                        if (!sel_r[0]) wdata <= bus.wr_data[sel_ch*DATA_W +: DATA_W];
                    end
                end
                // Read data is taken on the edge that closes the OE pulse,
                // while the SRAM is still guaranteed to be driving.
                STROBE: begin
                    if (!gnt_wr) bus.rd_data <= mem_dq;
                end
                CAPTURE: begin
                    if (gnt_wr) begin
                        wr_ptr[gnt_ch] <= wr_ptr[gnt_ch] + REG_W'(1);
                        cnt[gnt_ch]    <= cnt[gnt_ch] + CNT_W'(1);
                    end else begin
                        rd_ptr[gnt_ch] <= rd_ptr[gnt_ch] + REG_W'(1);
                        cnt[gnt_ch]    <= cnt[gnt_ch] - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.empty <= '1;
            bus.full  <= '0;
            bus.count <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bus.empty[c]                  <= (cnt[c] == '0);
                bus.full[c]                   <= (cnt[c] == CAP);
                bus.count[c*CNT_W +: CNT_W]   <= cnt[c];
            end
        end
    end
endmodule

// File: doc/sram_fifo_arb.md
# sram_fifo_arb

Multi-channel SRAM FIFO controller for the shared external 16-bit asynchronous SRAM. Splits the SRAM into `NCH` equal ring-buffer regions and serves one writer port and one reader port per region. Arbitration is round-robin, and each channel has its own flush. Sits between the SPI slave/master and wireless-control blocks and the SRAM pins, generalising the fixed two-FIFO controller.

## Interface
Parameters:
- `DATA_W`, 16: SRAM word width.
- `ADDR_W`, 18: SRAM word-address width.
- `NCH`, 2: channel count; power of two, 1..8. `CH_W = clog2(NCH)`; `REG_W = ADDR_W - CH_W` (region address bits).

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `wr_req`  in  NCH: write request per channel; level, held until `wr_ack`.
- `wr_data`  in  NCH*DATA_W: write word; channel c occupies bits [c*DATA_W +: DATA_W]; stable while `wr_req[c]` is high.
- `wr_ack`  out  NCH: one-cycle pulse; write committed.
- `rd_req`  in  NCH: read request per channel; level, held until `rd_ack`.
- `rd_ack`  out  NCH: one-cycle pulse; `rd_data` valid in the same cycle.
- `rd_data`  out  DATA_W: last word read; held until the next read completes.
- `flush`  in  NCH: one-cycle pulse; empties channel c.
- `empty`  out  NCH: channel count == 0.
- `full`  out  NCH: channel count == 2^REG_W.
- `count`  out  NCH*(REG_W+1): per-channel occupancy.
- `mem_addr`  out  ADDR_W: SRAM address.
- `mem_dq`  inout  DATA_W: SRAM data; driven only in write states, Z otherwise.
- `ce_n`, `oe_n`, `we_n`, `lb_n`, `ub_n`  out  1 each: SRAM strobes.

## Operation
- **Regions.** Channel c owns addresses {c[CH_W-1:0], ptr[REG_W-1:0]}. Per channel: `wr_ptr` and `rd_ptr` (REG_W bits, wrap naturally from 2^REG_W-1 to 0) and `cnt` (REG_W+1 bits).
- **Requesters.** There are 2*NCH requesters, indexed r = 2c (write c) and r = 2c+1 (read c).
  - A write requester is eligible when `wr_req[c] & ~full[c]`.
  - A read requester is eligible when `rd_req[c] & ~empty[c]`.
  - An ineligible request stays pending; it is never acked and never dropped.
- **Arbitration.** Round-robin pointer `rr` (reset 0). In IDLE, grant the first eligible r searching from `rr` upward with wrap. After a grant, `rr` = granted r + 1 mod 2*NCH.
- **FSM states** (reset IDLE):
  - IDLE: flush has priority over grants.
    - If any `flush` bit is set this cycle, clear `wr_ptr`, `rd_ptr` and `cnt` of every flagged channel and stay in IDLE; no grant this cycle.
    - Otherwise, if an eligible requester exists, latch the grant, drive `mem_addr` and (for writes) load the data register, and go to SETUP.
  - SETUP: `ce_n` = 0. Write: `mem_dq` driven. Next state is STROBE.
  - STROBE: write: `we_n` = 0; read: `oe_n` = 0. Next state is CAPTURE.
  - CAPTURE:
    - `we_n` = 1 and `oe_n` = 1.
    - Read: `rd_data` <= `mem_dq` sampled at this edge.
    - Update pointer and count: write: `wr_ptr`+1, `cnt`+1; read: `rd_ptr`+1, `cnt`-1.
    - Next state is ACK.
  - ACK: pulse the granted `wr_ack`/`rd_ack` bit and release `mem_dq`. Next state is IDLE.
- **Flush during a transfer.** A `flush` pulse arriving while not in IDLE is latched into a pending mask and applied at the next IDLE, before arbitration.
  - If the flushed channel is the one in flight, the transfer still completes and acks.
  - The flush then zeroes that channel, so a write in flight is lost.
- **Pin defaults.** `lb_n`, `ub_n` are tied 0. `ce_n` = 1 in IDLE (power save). `mem_dq` is driven from SETUP through CAPTURE of writes only.
- **Status.** `empty`, `full` and `count` are registered from `cnt`; they reflect the post-update value one cycle after CAPTURE.
  - Consequence: arbitration in IDLE uses status that is already current, since ACK separates CAPTURE from IDLE.

## Timing
- **Reset values:**
  - FSM IDLE, all pointers and counts 0, `rr` 0, pending flush 0.
  - `empty` all 1, `full` 0, `count` 0.
  - `wr_ack`, `rd_ack` 0, `rd_data` 0, `mem_addr` 0.
  - `ce_n`, `oe_n`, `we_n` 1; `lb_n`, `ub_n` 0; `mem_dq` Z.
- **Reset mid-transfer.** Strobes go inactive immediately (asynchronous). The access is abandoned with no ack.
- **Latency.** Request high in IDLE gives an ack 4 cycles later (IDLE→SETUP→STROBE→CAPTURE→ACK). Maximum throughput is one access per 5 cycles.
- **Handshake.** The requester must drop `req` on the edge at which it sees `ack` = 1. A `req` still high in the following IDLE is a new request.
- **Simultaneous events.**
  - Concurrent write and read to the same channel are served in round-robin order.
  - A read on a channel with `cnt` = 1 and a simultaneous write are both legal.
  - Flush in the same IDLE cycle as pending requests: flush first, requests arbitrated in the next cycle.

## Test plan
- **Write/read latency.** After reset, NCH=2: write 0xA5A5 on ch0, then read ch0. Required: `wr_ack` 4 cycles after `wr_req`; `mem_addr` = 0x00000 on the write; `rd_data` = 0xA5A5 with `rd_ack`; `empty[0]` back to 1.
- **Round-robin fairness.** Hold `wr_req` = 2'b11 with both channels empty. Required: grant order ch0, ch1, ch0, ch1; ch1 addresses start at 0x20000.
- **Full and wrap.** Set ADDR_W=4, NCH=2 (8 words per region). Write 8 words to ch1. Required: `full[1]` = 1; a 9th `wr_req` gets no ack; after one read it is acked at address 0x8 (ptr wrapped to 0).
- **Empty blocking.** `rd_req[0]` on an empty channel: no ack for 20 cycles. A `wr_req[0]` is then served, followed by the read.
- **Flush during a transfer.** Pulse `flush[0]` during the SETUP of a ch0 write with count 3. Required: the write still acks; next IDLE sets `count[0]` = 0 and `empty[0]` = 1; ch1 is unaffected.
- **Reset during strobe.** Assert `rst` during STROBE. Required: `we_n` = 1 and `mem_dq` = Z asynchronously, no ack, all counts 0.
